// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-to-1 arbitrated multiplexer feeding a single registered
// valid/ready output stage. The channel select is produced internally, either
// round-robin (MODE 0) or fixed lowest-index-first priority (MODE 1).
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   in_valid   [N]        channel i presents data
//   in_data    [N*WIDTH]  channel i at bits [i*WIDTH +: WIDTH]
//   in_ready   [N]        one-hot or zero: channel i is accepted this cycle
//   out_valid             output register holds data
//   out_data   [WIDTH]    registered data of the granted channel
//   out_sel    [SELW]     index of the channel that produced out_data
//   out_ready             downstream accepts out_data this cycle
//
// Handshake: a beat moves on a rising edge when valid and ready are both high
// on that side. The output register accepts a new beat whenever it is empty or
// is being drained in the same cycle (load), so a steady stream has no bubbles.
// in_ready is the grant gated by load; a channel that is not granted, or that
// drops in_valid, simply waits and has no effect on anybody else.

module rr_arb_mux #(
  parameter int WIDTH = 32,
  parameter int N     = 8,
  parameter int MODE  = 0,
  localparam int SELW = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_sel,
  input  logic               out_ready
);

  // ptr holds the most recently granted channel; the search starts just after
  // it. Resetting it to N-1 gives channel 0 top priority after reset.
  logic [SELW-1:0]  ptr;
  logic [N-1:0]     grant;
  logic [SELW-1:0]  grant_idx;
  logic [WIDTH-1:0] sel_data;
  logic             any_valid;
  logic             load;
  logic             xfer;

  assign any_valid = |in_valid;
  assign load      = ~out_valid | out_ready;
  assign xfer      = load & any_valid;
  assign in_ready  = grant & {N{load}};

  // Each channel gets a rank = its distance after ptr (round-robin) or its
  // own index (fixed priority); the valid channel with the smallest rank wins.
  always_comb begin
    int best_rank;
    int best_idx;
    int rank;
    best_rank = N;
    best_idx  = 0;
    rank      = 0;
    grant     = '0;
    for (int c = 0; c < N; c++) begin
      if (MODE == 0) begin
        rank = c - int'(ptr) - 1;
        if (rank < 0) rank = rank + N;
      end else begin
        rank = c;
      end
      if (in_valid[c] && (rank < best_rank)) begin
        best_rank = rank;
        best_idx  = c;
      end
    end
    for (int c = 0; c < N; c++) begin
      grant[c] = (best_rank < N) && (c == best_idx);
    end
    grant_idx = (best_rank < N) ? SELW'(best_idx) : '0;
  end

  // AND-OR select: non-granted channels are masked with zero, so unknown data
  // on an idle channel cannot reach out_data.
  always_comb begin
    sel_data = '0;
    for (int c = 0; c < N; c++) begin
      sel_data = sel_data | (in_data[c*WIDTH +: WIDTH] & {WIDTH{grant[c]}});
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= SELW'(N - 1);
    end else begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_sel   <= grant_idx;
        if (MODE == 0) ptr <= grant_idx;
      end else if (out_ready && out_valid) begin
        // Drained with nothing new to load; data and select keep last values.
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_arb_mux.sv
// tb_rr_arb_mux: drives three arbiters (N=8 round-robin, N=8 fixed priority,
// N=5 round-robin) from shared clock/reset/out_ready and compares every cycle
// against a behavioural model of each, plus a few directed sequences.

module tb_rr_arb_mux;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         out_ready;
  logic [255:0] din;
  logic [7:0]   vin [3];

  logic [7:0]  rdy0, rdy1;
  logic [4:0]  rdy2;
  logic        ov0, ov1, ov2;
  logic [31:0] od0, od1, od2;
  logic [2:0]  os0, os1, os2;

  rr_arb_mux #(.WIDTH(32), .N(8), .MODE(0)) u0 (
    .clk(clk), .reset(reset), .in_valid(vin[0]), .in_data(din),
    .in_ready(rdy0), .out_valid(ov0), .out_data(od0), .out_sel(os0),
    .out_ready(out_ready));

  rr_arb_mux #(.WIDTH(32), .N(8), .MODE(1)) u1 (
    .clk(clk), .reset(reset), .in_valid(vin[1]), .in_data(din),
    .in_ready(rdy1), .out_valid(ov1), .out_data(od1), .out_sel(os1),
    .out_ready(out_ready));

  rr_arb_mux #(.WIDTH(32), .N(5), .MODE(0)) u2 (
    .clk(clk), .reset(reset), .in_valid(vin[2][4:0]), .in_data(din[159:0]),
    .in_ready(rdy2), .out_valid(ov2), .out_data(od2), .out_sel(os2),
    .out_ready(out_ready));

  // scoreboard / model state
  int n_ch [3] = '{8, 8, 5};
  int md   [3] = '{0, 1, 0};
  bit          m_valid [3];
  logic [31:0] m_data  [3];
  int          m_sel   [3];
  int          m_last  [3];
  logic [31:0] exp_q [$];

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] dut_rdy(int m);
    case (m)
      0: return rdy0;
      1: return rdy1;
      default: return {3'b000, rdy2};
    endcase
  endfunction

  function automatic logic dut_valid(int m);
    case (m)
      0: return ov0;
      1: return ov1;
      default: return ov2;
    endcase
  endfunction

  function automatic logic [31:0] dut_data(int m);
    case (m)
      0: return od0;
      1: return od1;
      default: return od2;
    endcase
  endfunction

  function automatic logic [2:0] dut_sel(int m);
    case (m)
      0: return os0;
      1: return os1;
      default: return os2;
    endcase
  endfunction

  // Winner: walk the channels in circular order starting after the last
  // winner. Fixed priority never moves m_last off N-1, so its walk is 0,1,...
  function automatic int pick(int m);
    int c;
    for (int k = 1; k <= n_ch[m]; k++) begin
      c = (m_last[m] + k) % n_ch[m];
      if (vin[m][c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 3; m++) begin
      m_valid[m] = 1'b0;
      m_data[m]  = '0;
      m_sel[m]   = 0;
      m_last[m]  = n_ch[m] - 1;
    end
  endtask

  // Called just after a falling edge with inputs driven; checks, advances the
  // model on the rising edge and returns on the next falling edge.
  task automatic cycle(input string ph);
    int   g   [3];
    bit   ld  [3];
    logic [7:0] er;
    #1;
    for (int m = 0; m < 3; m++) begin
      g[m]  = pick(m);
      ld[m] = !m_valid[m] || out_ready;
      er    = (ld[m] && g[m] >= 0) ? 8'(1 << g[m]) : 8'h00;
      check($sformatf("%s_rdy%0d", ph, m), 64'(dut_rdy(m)), 64'(er));
      check($sformatf("%s_val%0d", ph, m), 64'(dut_valid(m)), 64'(m_valid[m]));
      check($sformatf("%s_dat%0d", ph, m), 64'(dut_data(m)), 64'(m_data[m]));
      check($sformatf("%s_sel%0d", ph, m), 64'(dut_sel(m)), 64'(m_sel[m]));
    end
    @(posedge clk);
    for (int m = 0; m < 3; m++) begin
      if (ld[m] && g[m] >= 0) begin
        m_valid[m] = 1'b1;
        m_data[m]  = din[g[m]*32 +: 32];
        m_sel[m]   = g[m];
        if (md[m] == 0) m_last[m] = g[m];
      end else if (out_ready && m_valid[m]) begin
        m_valid[m] = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    reset = 1'b0;
    model_reset();
    for (int m = 0; m < 3; m++) vin[m] = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  logic [31:0] held;

  initial begin
    reset     = 1'b1;
    out_ready = 1'b0;
    din       = '0;
    for (int m = 0; m < 3; m++) vin[m] = 8'h00;
    @(negedge clk);
    do_reset();

    // Reset state with nothing requesting.
    cycle("rst");
    cycle("idle");

    // Full load, round-robin sweeps 0..7 twice with no bubbles.
    for (int i = 0; i < 8; i++) din[i*32 +: 32] = 32'hA0 + 32'(i);
    out_ready = 1'b1;
    for (int m = 0; m < 3; m++) vin[m] = 8'hFF;
    for (int k = 0; k < 16; k++) begin
      cycle("full");
      check("full_seq", 64'(os0), 64'(k % 8));
      check("full_dat", 64'(od0), 64'(32'hA0 + 32'(k % 8)));
      check("full_fix", 64'(os1), 64'd0);
    end

    // Stall: only ch5 requests while downstream holds off.
    held = od0;
    out_ready = 1'b0;
    for (int m = 0; m < 3; m++) vin[m] = 8'h20;
    for (int k = 0; k < 4; k++) begin
      cycle("stall");
      check("stall_hold", 64'(od0), 64'(held));
    end
    out_ready = 1'b1;
    cycle("unstall");
    check("unstall_sel", 64'(os0), 64'd5);

    // Fixed priority starves ch5 and ch7.
    vin[1] = 8'b1010_0100;
    for (int k = 0; k < 4; k++) begin
      cycle("prio");
      check("prio_sel", 64'(os1), 64'd2);
    end

    // Wrap-around on the 5-channel arbiter straight out of reset.
    do_reset();
    out_ready = 1'b1;
    vin[2] = 8'b0001_1;
    exp_q = '{32'd0, 32'd1, 32'd0};
    while (exp_q.size() > 0) begin
      cycle("wrap");
      check("wrap_sel", 64'(os2), 64'(exp_q.pop_front()));
    end

    // Asynchronous reset while holding data.
    vin[2] = 8'h00;
    din[31:0] = 32'hDEADBEEF;
    vin[0] = 8'h01;
    cycle("pre_ar");
    check("pre_ar_dat", 64'(od0), 64'hDEADBEEF);
    #2;
    reset = 1'b0;
    #1;
    check("ar_valid", 64'(ov0), 64'd0);
    check("ar_data", 64'(od0), 64'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    vin[0] = 8'b0110_0000;
    cycle("post_ar");
    check("post_ar_sel", 64'(os0), 64'd5);

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < 8; i++) din[i*32 +: 32] = $urandom;
      for (int m = 0; m < 3; m++)
        vin[m] = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
